// File: rtl/alu_seq_if.sv
// alu_seq request/result bundle.
// master drives operations, slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic [WIDTH-1:0] res;
  logic             z;
  logic             n;
  logic             c;
  logic             v;

  modport master (
    output in_valid, a, b, op,
    input  in_ready, out_valid, res, z, n, c, v
  );

  modport slave (
    input  in_valid, a, b, op,
    output in_ready, out_valid, res, z, n, c, v
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU with registered Z/N/C/V flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_NEG = 3'b110;

  logic             rdy;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;

  logic             is_arith;
  logic             is_and;
  logic             is_or;
  logic             is_xor;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;

  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic             z_q;
  logic             n_q;
  logic             c_q;
  logic             v_q;

  assign is_arith = (bus.op == OP_ADD) |
                    (bus.op == OP_SUB) |
                    (bus.op == OP_NEG);
  assign is_and   = (bus.op == OP_AND);
  assign is_or    = (bus.op == OP_OR);
  assign is_xor   = (bus.op == OP_XOR);

  // Adder operand select: sub and neg reuse the adder via ~y + 1.
  always_comb begin
    x   = bus.a;
    y   = bus.b;
    cin = 1'b0;
    if (bus.op == OP_SUB) begin
      y   = ~bus.b;
      cin = 1'b1;
    end else if (bus.op == OP_NEG) begin
      x   = '0;
      y   = ~bus.a;
      cin = 1'b1;
    end
  end

  assign sum = {1'b0, x} + {1'b0, y} +
               {{WIDTH{1'b0}}, cin};

  // Single-cycle result mux; anything unmatched is reserved.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (1'b1)
      is_arith: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (x[WIDTH-1] == y[WIDTH-1]) &
                 (sum[WIDTH-1] != x[WIDTH-1]);
      end
      is_and:  sc_res = bus.a & bus.b;
      is_or:   sc_res = bus.a | bus.b;
      is_xor:  sc_res = bus.a ^ bus.b;
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign mul_res = acc_nxt;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, intake ready and multiply start/finish strobes.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid && bus.op == OP_MUL) begin
          mul_start = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (cnt == CW'(WIDTH - 1)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath: load on accept, one iteration per MUL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_start) begin
      cnt    <= '0;
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= mul_done ? '0 : cnt + 1'b1;
    end
  end
`else
  assign rdy       = 1'b1;
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
`endif

  assign accept = bus.in_valid & rdy;

  // Result and flag registers; hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (mul_done) begin
        valid_q <= 1'b1;
        res_q   <= mul_res;
        z_q     <= (mul_res == '0);
        n_q     <= mul_res[WIDTH-1];
        c_q     <= 1'b0;
        v_q     <= 1'b0;
      end else if (accept && !mul_start) begin
        valid_q <= 1'b1;
        res_q   <= sc_res;
        z_q     <= (sc_res == '0);
        n_q     <= sc_res[WIDTH-1];
        c_q     <= sc_c;
        v_q     <= sc_v;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = valid_q;
  assign bus.res       = res_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32).
// Directed steps plus random ops against an arithmetic model.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [35:0] model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    logic [63:0] us;
    logic        c;
    logic        v;
    longint      sa;
    longint      sb;
    longint      sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        us = {32'b0, a} + {32'b0, b};
        c  = us[32];
        sr = sa + sb;
        v  = (sr > SMAX) || (sr < SMIN);
      end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
`ifdef ALU_SEQ_MUL_EN
      3'd4: r = a * b;
`endif
      3'd5: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > SMAX) || (sr < SMIN);
      end
      3'd6: begin
        r  = -a;
        c  = (a == 32'd0);
        sr = -sa;
        v  = (sr > SMAX) || (sr < SMIN);
      end
      default: r = '0;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [35:0] exp);
    check({tag, " valid"}, bus.out_valid, 1);
    check({tag, " res"}, bus.res, exp[35:4]);
    check({tag, " zncv"}, {bus.z, bus.n, bus.c, bus.v}, exp[3:0]);
  endtask

  task automatic do_op(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int          cyc;
    logic [35:0] exp;
    exp = model(op, a, b);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk);
    #1;
`ifdef ALU_SEQ_MUL_EN
    if (op == 3'b100) begin
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check({tag, " mul latency"}, cyc, W);
    end
`endif
    check_out(tag, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.a  = '0;
    bus.b  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst valid", bus.out_valid, 0);
    check("rst res", bus.res, 0);
    check("rst zncv", {bus.z, bus.n, bus.c, bus.v}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst ready", bus.in_ready, 1);
    check("post-rst valid", bus.out_valid, 0);

    do_op("add ovf", 3'd0, 32'h7FFF_FFFF, 32'd1);
    check("add ovf const", bus.res, 32'h8000_0000);
    check("add ovf flags", {bus.z, bus.n, bus.c, bus.v}, 4'b0101);

    do_op("sub eq", 3'd5, 32'd5, 32'd5);
    check("sub eq flags", {bus.z, bus.n, bus.c, bus.v}, 4'b1010);
    do_op("sub lt", 3'd5, 32'd3, 32'd5);
    check("sub lt const", bus.res, 32'hFFFF_FFFE);
    check("sub lt flags", {bus.z, bus.n, bus.c, bus.v}, 4'b0100);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("valid drop", bus.out_valid, 0);
    check("hold res", bus.res, 32'hFFFF_FFFE);

    do_op("neg min", 3'd6, 32'h8000_0000, 32'd0);
    check("neg min flags", {bus.z, bus.n, bus.c, bus.v}, 4'b0101);
    do_op("neg zero", 3'd6, 32'd0, 32'd9);
    check("neg zero flags", {bus.z, bus.n, bus.c, bus.v}, 4'b1010);
    do_op("and", 3'd1, 32'hF0F0_1234, 32'hFF00_FF00);
    do_op("or", 3'd2, 32'hF0F0_1234, 32'h0F00_0001);
    do_op("xor", 3'd3, 32'hAAAA_5555, 32'hAAAA_5555);
    do_op("rsvd", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    check("rsvd const", {bus.res, bus.z}, {32'd0, 1'b1});
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

`ifdef ALU_SEQ_MUL_EN
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.a  = 32'h0000_FFFF;
    bus.b  = 32'h0001_0001;
    @(posedge clk);
    #1;
    bus.op = 3'd0;
    bus.a  = 32'd10;
    bus.b  = 32'd20;
    for (int i = 0; i < W; i++) begin
      check("mul busy ready", bus.in_ready, 0);
      check("mul busy valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
    end
    check_out("mul dir", model(3'd4, 32'h0000_FFFF, 32'h0001_0001));
    check("mul dir const", bus.res, 32'hFFFF_FFFF);
    check("mul dir flags", {bus.z, bus.n, bus.c, bus.v}, 4'b0100);
    check("mul done ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check_out("add after mul", model(3'd0, 32'd10, 32'd20));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("after mul drop", bus.out_valid, 0);
`else
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.a  = 32'd7;
    bus.b  = 32'd9;
    for (int i = 0; i < 4; i++) begin
      check("mul off ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
    end
    do_op("mul off", 3'd4, 32'd3, 32'd4);
    check("mul off const", {bus.res, bus.z}, {32'd0, 1'b1});
    check("mul off ready2", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
`endif

`ifdef ALU_SEQ_MUL_EN
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.a  = 32'h0001_2345;
    bus.b  = 32'h0000_0777;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`else
    do_op("pre-rst add", 3'd0, 32'hFFFF_FFFF, 32'd2);
    bus.in_valid = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    check("mid rst valid", bus.out_valid, 0);
    check("mid rst res", bus.res, 0);
    check("mid rst zncv", {bus.z, bus.n, bus.c, bus.v}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid rst ready", bus.in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      check("no late valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
    end
    check("rst ready idle", bus.in_ready, 1);

    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. Accepts one operation per `in_valid`/`in_ready` handshake and registers the result with Z/N/C/V flags. Adds logic ops and an optional iterative shift-add multiplier, which is multi-cycle and stalls intake. Sits in the EX stage and feeds the EX/MEM register and the branch-flag logic.

## Interface
- `WIDTH`, default 32: operand, result and multiplier iteration width; legal range 4..64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; handshake is `in_valid & in_ready` at a rising edge.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  opcode:
  - 000 add; 001 and; 010 or; 011 xor.
  - 100 mul; 101 sub (a−b); 110 neg (−a); 111 reserved.
- `out_valid`  out  1  one-cycle pulse; `res` and flags are new this cycle.
- `res`  out  WIDTH  result register.
- `z`  out  1  `res == 0`.
- `n`  out  1  `res[WIDTH-1]`.
- `c`  out  1  carry-out.
- `v`  out  1  signed overflow.

## Operation
- The FSM has two states: IDLE and MUL.
  - `in_ready = 1` in IDLE, `0` in MUL.
- Add, sub and neg are computed as a WIDTH+1-bit sum.
  - add: `a + b`.
  - sub: `a + ~b + 1`; c=1 means no borrow.
  - neg: `0 + ~a + 1`; c=1 only when a==0.
  - v: operand signs match and the result sign differs. For neg, v=1 only when a is the most-negative value.
- and, or, xor: bitwise; c=v=0.
- Reserved opcode (111): res=0, z=1, n=c=v=0, with single-cycle latency.
- mul (with `ALU_SEQ_MUL_EN`), unsigned shift-add:
  - Acceptance latches a into the multiplicand, b into the multiplier and clears the accumulator. FSM → MUL with counter=0.
  - Each MUL cycle: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - `res` = low WIDTH bits of the product. c=v=0; z and n are taken from `res`.
  - The FSM returns to IDLE on the edge that completes iteration WIDTH−1.
- `res` and flags hold their values between results; there is no backpressure on the output.
- `in_valid`, `a`, `b` and `op` are ignored while `in_ready=0`.
- Reset, including mid-multiply:
  - FSM → IDLE, counter=0.
  - out_valid=0, res=0, z=n=c=v=0.
  - in_ready=1 from the first cycle after release.
  - An aborted multiply produces no output.

## Timing
- Single-cycle ops (add/and/or/xor/sub/neg/111):
  - res, flags and out_valid update on the accepting edge, i.e. visible in the next cycle; latency 1.
  - Back-to-back ops are accepted every cycle, giving continuous out_valid.
- mul:
  - The accepting edge loads the operands.
  - The next WIDTH edges iterate; the last of these writes res and flags and pulses out_valid. Latency is WIDTH+1 edges.
  - in_ready is 0 for exactly WIDTH cycles and is 1 again in the out_valid cycle, so a new op may be accepted in that same cycle.
- out_valid is high for exactly one cycle per accepted op.

## Configuration
- `ALU_SEQ_MUL_EN` defined: op 100 is the iterative multiplier above; the FSM, counter and shift registers are built.
- Not defined: op 100 behaves as reserved (res=0, z=1, latency 1). in_ready is constant 1 and no multiplier logic is synthesised.

## Test plan
All scenarios use WIDTH=32.
- add a=0x7FFFFFFF, b=1 → next cycle out_valid=1, res=0x80000000, n=1, v=1, c=0, z=0.
- sub a=5, b=5, then sub a=3, b=5 on consecutive cycles:
  - first result: res=0, z=1, c=1.
  - second result: res=0xFFFFFFFE, n=1, c=0.
  - out_valid high on 2 consecutive cycles.
- neg a=0x80000000 → res=0x80000000, n=1, v=1, c=0. Then neg a=0 → res=0, z=1, c=1, v=0.
- mul (macro on) a=0x0000FFFF, b=0x00010001 →
  - in_ready low 32 cycles; an add driven during the busy window is ignored.
  - out_valid at edge 33 with res=0xFFFFFFFF, n=1, c=v=0.
  - add accepted in the out_valid cycle completes 1 cycle later.
- Reset asserted 10 cycles into a mul → out_valid=0, res=0, z=n=c=v=0, in_ready=1 after release; no late out_valid.
- Macro off: op=100, a=3, b=4 → next cycle res=0, z=1; in_ready never drops.
